// File: rtl/feature_sequencer_pkg.sv
// Shared configuration for the inference pipeline: widths, layer sizes,
// requantization shift and the feature-sequencer state encoding.
package feature_sequencer_pkg;

   localparam int DataWidth    = 16;
   localparam int AccWidth     = 48;
   localparam int RequantShift = 8;
   localparam int AddrWidth    = 7;

   localparam int L1Neurons    = 64;
   localparam int L1Weights    = 128;
   localparam int L2Neurons    = 10;
   localparam int L2Weights    = L1Neurons;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM,
      S_HOLD
   } seq_state_e;

endpackage

// File: rtl/feature_sequencer_relu_requant.sv
// Combinational ReLU + arithmetic right shift + positive saturation,
// shared by every layer that narrows an accumulator to a feature.
module relu_requant #(
   parameter int IN_W  = 48,
   parameter int OUT_W = 16,
   parameter int SHIFT = 8
) (
   input  logic signed [IN_W-1:0]  x,
   output logic signed [OUT_W-1:0] y
);

   logic [IN_W-1:0] shifted;
   logic            sat;

   always_comb begin
      shifted = x >>> SHIFT;
      // any set bit at or above the output sign position exceeds the max
      sat     = |shifted[IN_W-1:OUT_W-1];
      if (x[IN_W-1] || x == '0) begin
         y = '0;
      end else if (sat) begin
         y = {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
         y = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/feature_sequencer.sv
// Captures a vector of upstream accumulators and streams one requantized
// feature per cycle to the downstream layer, framing it with clear/hold.
module feature_sequencer
   import feature_sequencer_pkg::*;
#(
   parameter int N_IN  = L2Weights,
   parameter int ACC_W = AccWidth,
   parameter int DW    = DataWidth,
   parameter int SHIFT = RequantShift
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [N_IN*ACC_W-1:0]  layer_in,
   output logic signed [DW-1:0]   feature_out,
   output logic [AddrWidth-1:0]   addr,
   output logic                   acc_clr,
   output logic                   busy,
   output logic                   done,
   output logic                   result_valid
);

   localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int BANK = 1 << IW;

   typedef logic [IW-1:0] idx_t;

   seq_state_e              state, state_next;
   idx_t                    idx, idx_next;
   logic signed [ACC_W-1:0] bank [BANK];
   logic signed [DW-1:0]    q_feat, feature_next;
   logic [AddrWidth-1:0]    addr_next;
   logic                    acc_clr_next, busy_next, done_next, rv_next;
   logic                    accept, last;

   assign accept = start && (state == S_IDLE || state == S_HOLD);
   assign last   = (idx == idx_t'(N_IN - 1));

   // Bank is deliberately unreset; it is only read after a LOAD has filled it.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned k = 0; k < N_IN; k++) begin
            bank[idx_t'(k)] <= layer_in[k*ACC_W +: ACC_W];
         end
      end
   end

   relu_requant #(
      .IN_W (ACC_W),
      .OUT_W(DW),
      .SHIFT(SHIFT)
   ) u_requant (
      .x(bank[idx_next]),
      .y(q_feat)
   );

   // Outputs are derived from the next state so they register in step with it.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      unique case (state)
         S_IDLE:   if (start) state_next = S_LOAD;
         S_LOAD: begin
            state_next = S_STREAM;
            idx_next   = '0;
         end
         S_STREAM: begin
            if (last) begin
               state_next = S_HOLD;
               idx_next   = '0;
            end else begin
               idx_next   = idx + 1'b1;
            end
         end
         S_HOLD:   if (start) state_next = S_LOAD;
         default:  state_next = S_IDLE;
      endcase

      acc_clr_next = (state_next == S_IDLE) || (state_next == S_LOAD);
      busy_next    = (state_next == S_LOAD) || (state_next == S_STREAM);
      rv_next      = (state_next == S_HOLD);
      done_next    = (state == S_STREAM) && (state_next == S_HOLD);
      feature_next = (state_next == S_STREAM) ? q_feat : '0;
      addr_next    = (state_next == S_STREAM) ? AddrWidth'(idx_next) : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         feature_out  <= '0;
         addr         <= '0;
         acc_clr      <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state        <= state_next;
         idx          <= idx_next;
         feature_out  <= feature_next;
         addr         <= addr_next;
         acc_clr      <= acc_clr_next;
         busy         <= busy_next;
         done         <= done_next;
         result_valid <= rv_next;
      end
   end

endmodule

// File: doc/feature_sequencer.md
FEATURE_SEQUENCER -- requirements
Module: feature_sequencer

Interface
REQ-001 Parameter N_IN, default 64: number of features streamed per inference, i.e. the downstream layer's weights per neuron; legal range 1..128.
REQ-002 Parameter ACC_W, default 48: width of each packed upstream accumulator.
REQ-003 Parameter DW, default `DataWidth: width of the signed output feature.
REQ-004 Parameter SHIFT, default 8: arithmetic right-shift applied during requantization.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle request to stream a new feature vector.
REQ-009 layer_in  input  N_IN*ACC_W  packed signed upstream accumulators; element k is at [k*ACC_W +: ACC_W].
REQ-010 feature_out  output  DW  signed feature to the downstream layer's feature_in.
REQ-011 addr  output  7  feature index to the downstream layer's addr.
REQ-012 acc_clr  output  1  active-high synchronous bias-load/clear for the downstream layer's rst.
REQ-013 busy  output  1  high in LOAD and STREAM.
REQ-014 done  output  1  one-cycle pulse when the last feature has been consumed.
REQ-015 result_valid  output  1  high while the downstream accumulators hold a complete result.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, STREAM and HOLD; all outputs SHALL be registered.
REQ-017 IDLE: acc_clr=1, feature_out=0, addr=0; start -> LOAD.
REQ-018 LOAD (exactly 1 cycle): acc_clr=1, feature_out=0; layer_in is captured into an internal N_IN-entry bank on the edge that accepts start.
REQ-019 STREAM (exactly N_IN cycles): acc_clr=0; on cycle i (0-based) addr=i and feature_out=q(bank[i]); after i=N_IN-1 -> HOLD.
REQ-020 HOLD: acc_clr=0, feature_out=0, addr=0, result_valid=1; done=1 only on the first HOLD cycle; start -> LOAD.
REQ-021 Latency: when start is accepted at edge E0, LOAD is cycle E0..E1, the first feature appears after E1, and done/result_valid rise after edge E0+N_IN+1.
REQ-022 feature_out SHALL be 0 in every non-STREAM state, so that a free-running downstream accumulator adds nothing.
REQ-023 q(x): if x<=0 (ReLU), 0; else y=x>>>SHIFT; if y>2^(DW-1)-1, saturate to 2^(DW-1)-1; else y truncated to DW bits.
REQ-024 start in LOAD or STREAM SHALL be ignored, with no restart and no bank recapture.
REQ-025 start in HOLD SHALL clear result_valid on the next edge and re-run LOAD/STREAM.
REQ-026 Changes to layer_in after capture SHALL NOT affect the stream in progress.
REQ-027 When N_IN=1, STREAM SHALL last 1 cycle with addr=0.

Reset
REQ-028 Asserting rst at any time, including mid-STREAM, SHALL immediately force state=IDLE, feature_out=0, addr=0, acc_clr=1, busy=0, done=0 and result_valid=0.
REQ-029 The capture bank need not be reset; its contents SHALL NOT be observable before the first LOAD.
REQ-030 Deasserting rst SHALL leave the block in IDLE; the first start is accepted on the first rising edge at which rst is high.

Structure
REQ-031 DataWidth, the 48-bit accumulator width, per-layer neuron/weight counts and SHIFT SHALL live in the shared config header/package.
REQ-032 The requantizer (ReLU + shift + saturate) SHALL be a separate combinational sub-module, relu_requant, that is reused by later layers.

Verification
REQ-033 N_IN=4, SHIFT=8, layer_in={0x300,-5,0x7FFFFFFF,0x80}, start -> acc_clr 1 for one cycle, then addr 0,1,2,3 with feature 3,0,32767 (saturated, DW=16),0; done after cycle 6.
REQ-034 The block connected to the downstream layer with unit weights and zero bias, vector {1<<8,2<<8,3<<8,4<<8} -> downstream accumulator = 10 when result_valid rises, and it stays 10 for 20 further idle cycles.
REQ-035 start pulsed again at STREAM cycle 2 -> addr sequence 0..N_IN-1 unchanged and a single done pulse.
REQ-036 rst asserted during STREAM at addr=1 -> all outputs at reset values at once; the next start streams from addr=0.
REQ-037 start in HOLD with a new vector -> result_valid drops, acc_clr pulses once, and the new result is correct with no residue from the previous vector.
REQ-038 layer_in changed every cycle during STREAM -> the streamed features match the values captured at start.
